if_fetch: RTL

- Instruction-fetch stage: owns the PC and issues word reads on the instruction bus.
- Produces the per-cycle if_pc / if_inst / if_excepttype / if_isbubble bundle that the IF/ID pipeline register samples.
- Honours the stall vector and flush, applies branch redirects, and raises a stall request while a bus read is outstanding.

---
 rtl/if_fetch.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues word reads on the instruction bus
// and presents one pc/inst/exception/bubble bundle per cycle to the IF/ID register.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          ADEL_BIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_ack,
    input  logic [31:0] ibus_data,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic [31:0] if_excepttype,
    output logic        if_isbubble,
    output logic        stallreq_if
);

    localparam logic [1:0]  ST_FETCH   = 2'd0;
    localparam logic [1:0]  ST_HOLD    = 2'd1;
    localparam logic [1:0]  ST_DISCARD = 2'd2;
    localparam logic [31:0] ADEL_MASK  = 32'd1 << ADEL_BIT;

    logic [1:0]  state_r;
    logic [31:0] pc_r;
    logic [31:0] req_addr_r;
    logic [31:0] hold_inst_r;
    logic [31:0] hold_exc_r;
    logic        br_pend_r;
    logic [31:0] br_tgt_r;

    logic [1:0]  state_s;
    logic [31:0] pc_s;
    logic [31:0] req_addr_s;
    logic [31:0] hold_inst_s;
    logic [31:0] hold_exc_s;
    logic        br_pend_s;
    logic [31:0] br_tgt_s;

    logic        aligned_s;
    logic        complete_s;
    logic        advance_s;
    logic        br_clear_s;
    logic [31:0] next_pc_s;
    logic [31:0] fetch_inst_s;
    logic [31:0] fetch_exc_s;

    // Fetch-slot decode: a misaligned PC completes at once with an address error.
    always_comb begin
        aligned_s  = (pc_r[1:0] == 2'b00);
        complete_s = !aligned_s || ibus_ack;
        next_pc_s  = br_pend_r ? br_tgt_r : (branch_flag ? branch_target : pc_r + 32'd4);
        if (aligned_s) begin
            fetch_inst_s = ibus_data;
            fetch_exc_s  = 32'd0;
        end else begin
            fetch_inst_s = 32'd0;
            fetch_exc_s  = ADEL_MASK;
        end
    end

    // Output bundle per state; reset forces an idle bus and a bubble without waiting for a clock.
    always_comb begin
        ibus_req      = 1'b0;
        ibus_addr     = 32'd0;
        if_pc         = 32'd0;
        if_inst       = 32'd0;
        if_excepttype = 32'd0;
        if_isbubble   = 1'b1;
        stallreq_if   = 1'b0;
        if (!rst) begin
            ibus_req = 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    ibus_req  = aligned_s;
                    ibus_addr = pc_r;
                    if_pc     = pc_r;
                    if (complete_s) begin
                        if_inst       = fetch_inst_s;
                        if_excepttype = fetch_exc_s;
                        if_isbubble   = 1'b0;
                    end else begin
                        stallreq_if = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if_pc         = pc_r;
                    if_inst       = hold_inst_r;
                    if_excepttype = hold_exc_r;
                    if_isbubble   = 1'b0;
                end
                ST_DISCARD: begin
                    ibus_req  = 1'b1;
                    ibus_addr = req_addr_r;
                end
                default: begin
                    ibus_req = 1'b0;
                end
            endcase
        end
    end

    // Next-state logic: flush wins, then advance, then hold the completed word under stall.
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        req_addr_s  = req_addr_r;
        hold_inst_s = hold_inst_r;
        hold_exc_s  = hold_exc_r;
        advance_s   = 1'b0;
        br_clear_s  = 1'b0;
        case (state_r)
            ST_FETCH: begin
                if (flush) begin
                    pc_s       = new_pc;
                    br_clear_s = 1'b1;
                    if (aligned_s && !ibus_ack) begin
                        // The outstanding read must still be retired on the bus.
                        req_addr_s = pc_r;
                        state_s    = ST_DISCARD;
                    end else begin
                        state_s = ST_FETCH;
                    end
                end else if (complete_s && !stall[0]) begin
                    advance_s = 1'b1;
                    pc_s      = next_pc_s;
                    state_s   = ST_FETCH;
                end else if (complete_s) begin
                    hold_inst_s = fetch_inst_s;
                    hold_exc_s  = fetch_exc_s;
                    state_s     = ST_HOLD;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    pc_s       = new_pc;
                    br_clear_s = 1'b1;
                    state_s    = ST_FETCH;
                end else if (!stall[0]) begin
                    advance_s = 1'b1;
                    pc_s      = next_pc_s;
                    state_s   = ST_FETCH;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_DISCARD: begin
                if (flush) begin
                    pc_s = new_pc;
                end else begin
                    pc_s = pc_r;
                end
                if (ibus_ack) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_DISCARD;
                end
            end
            default: begin
                state_s = ST_FETCH;
            end
        endcase
    end

    // Remember a taken branch that arrived while the PC could not move.
    always_comb begin
        br_pend_s = br_pend_r;
        br_tgt_s  = br_tgt_r;
        if (br_clear_s || advance_s) begin
            br_pend_s = 1'b0;
        end else if (branch_flag && !flush) begin
            br_pend_s = 1'b1;
            br_tgt_s  = branch_target;
        end else begin
            br_pend_s = br_pend_r;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_FETCH;
            pc_r        <= RESET_PC;
            req_addr_r  <= 32'd0;
            hold_inst_r <= 32'd0;
            hold_exc_r  <= 32'd0;
            br_pend_r   <= 1'b0;
            br_tgt_r    <= 32'd0;
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            req_addr_r  <= req_addr_s;
            hold_inst_r <= hold_inst_s;
            hold_exc_r  <= hold_exc_s;
            br_pend_r   <= br_pend_s;
            br_tgt_r    <= br_tgt_s;
        end
    end

endmodule
